// File: rtl/chacha_round_engine.sv
// Iterative ChaCha round engine: one quarter round per clock, then a feed-forward
// add of the original state, delivered through a valid/ready output handshake.
module chacha_round_engine #(
    parameter int W      = 8,
    parameter int ROUNDS = 20,
    parameter int ROT_A  = 4,
    parameter int ROT_B  = 3,
    parameter int ROT_C  = 2,
    parameter int ROT_D  = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [16*W-1:0] state_in,
    output logic            busy,
    output logic [1:0]      qr_idx,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [16*W-1:0] state_out
);

    localparam int NW = 16;
    localparam logic [5:0] LAST_ROUND = 6'(ROUNDS - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUND = 2'd1,
        ST_FINAL = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t            state_r;
    state_t            state_next_s;
    logic [W-1:0]      working_r [NW];
    logic [W-1:0]      orig_r    [NW];
    logic [W-1:0]      working_next_s [NW];
    logic [5:0]        round_cnt_r;
    logic [1:0]        qr_idx_r;
    logic              busy_r;
    logic              out_valid_r;
    logic [16*W-1:0]   state_out_r;
    logic [16*W-1:0]   sum_s;

    logic              load_s;
    logic              step_s;
    logic              finish_s;
    logic              release_s;
    logic              last_qr_s;
    logic              diag_s;
    logic [3:0]        lane_a_s;
    logic [3:0]        lane_b_s;
    logic [3:0]        lane_c_s;
    logic [3:0]        lane_d_s;
    logic [4*W-1:0]    qr_out_s;

    function automatic logic [W-1:0] rotl(input logic [W-1:0] x, input int n);
        return (x << n) | (x >> (W - n));
    endfunction

    // Returns the updated words packed as {d, c, b, a}.
    function automatic logic [4*W-1:0] quarter_round(
        input logic [W-1:0] a_in,
        input logic [W-1:0] b_in,
        input logic [W-1:0] c_in,
        input logic [W-1:0] d_in
    );
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] c;
        logic [W-1:0] d;
        a = a_in;
        b = b_in;
        c = c_in;
        d = d_in;
        a = a + b;
        d = rotl(d ^ a, ROT_A);
        c = c + d;
        b = rotl(b ^ c, ROT_B);
        a = a + b;
        d = rotl(d ^ a, ROT_C);
        c = c + d;
        b = rotl(b ^ c, ROT_D);
        return {d, c, b, a};
    endfunction

    // Lane selection: diagonal rounds skew rows b, c, d by 1, 2, 3 columns.
    always_comb begin
        diag_s   = round_cnt_r[0];
        lane_a_s = {2'b00, qr_idx_r};
        lane_b_s = {2'b01, qr_idx_r + {1'b0, diag_s}};
        lane_c_s = {2'b10, qr_idx_r + {diag_s, 1'b0}};
        lane_d_s = {2'b11, qr_idx_r + {diag_s, diag_s}};
        qr_out_s = quarter_round(working_r[lane_a_s], working_r[lane_b_s],
                                 working_r[lane_c_s], working_r[lane_d_s]);
    end

    // Working state after applying the selected quarter round.
    always_comb begin
        for (int i = 0; i < NW; i++) begin
            working_next_s[i] = working_r[i];
        end
        working_next_s[lane_a_s] = qr_out_s[W-1:0];
        working_next_s[lane_b_s] = qr_out_s[2*W-1:W];
        working_next_s[lane_c_s] = qr_out_s[3*W-1:2*W];
        working_next_s[lane_d_s] = qr_out_s[4*W-1:3*W];
    end

    // Feed-forward sum of working and original state.
    always_comb begin
        sum_s = '0;
        for (int i = 0; i < NW; i++) begin
            sum_s[W*i +: W] = working_r[i] + orig_r[i];
        end
    end

    // Next-state logic and datapath control strobes.
    always_comb begin
        state_next_s = state_r;
        load_s       = 1'b0;
        step_s       = 1'b0;
        finish_s     = 1'b0;
        release_s    = 1'b0;
        last_qr_s    = (qr_idx_r == 2'd3) && (round_cnt_r == LAST_ROUND);
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    load_s       = 1'b1;
                    state_next_s = ST_ROUND;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_ROUND: begin
                step_s = 1'b1;
                if (last_qr_s) begin
                    state_next_s = ST_FINAL;
                end else begin
                    state_next_s = ST_ROUND;
                end
            end
            ST_FINAL: begin
                finish_s     = 1'b1;
                state_next_s = ST_DONE;
            end
            ST_DONE: begin
                if (out_valid_r && out_ready) begin
                    release_s    = 1'b1;
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_DONE;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Working/original state, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NW; i++) begin
                working_r[i] <= '0;
                orig_r[i]    <= '0;
            end
            round_cnt_r <= 6'd0;
            qr_idx_r    <= 2'd0;
            busy_r      <= 1'b0;
            out_valid_r <= 1'b0;
            state_out_r <= '0;
        end else begin
            if (load_s) begin
                for (int i = 0; i < NW; i++) begin
                    working_r[i] <= state_in[W*i +: W];
                    orig_r[i]    <= state_in[W*i +: W];
                end
                round_cnt_r <= 6'd0;
                qr_idx_r    <= 2'd0;
                busy_r      <= 1'b1;
            end else if (step_s) begin
                for (int i = 0; i < NW; i++) begin
                    working_r[i] <= working_next_s[i];
                end
                qr_idx_r <= qr_idx_r + 2'd1;
                if (qr_idx_r == 2'd3) begin
                    round_cnt_r <= round_cnt_r + 6'd1;
                end
            end else if (finish_s) begin
                state_out_r <= sum_s;
                out_valid_r <= 1'b1;
            end else if (release_s) begin
                out_valid_r <= 1'b0;
                busy_r      <= 1'b0;
            end
        end
    end

    assign busy      = busy_r;
    assign qr_idx    = qr_idx_r;
    assign out_valid = out_valid_r;
    assign state_out = state_out_r;

endmodule
